// File: rtl/uart_rx_cfg_pkg.sv
// uart_rx_cfg_pkg: shared UART receiver definitions (baud divider width, FSM states, word-length encoding).
package uart_rx_cfg_pkg;

    localparam int UART_BAUD_DIV_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        DB5 = 2'b00,
        DB6 = 2'b01,
        DB7 = 2'b10,
        DB8 = 2'b11
    } data_bits_e;

    // Index of the final data bit for a given word-length code (5..8 bits -> 4..7).
    function automatic logic [2:0] last_bit_idx(input data_bits_e db);
        return {1'b0, db} + 3'd4;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO; head is zero while empty.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign valid_o   = count_q != '0;
    assign full_o    = count_q == (AW+1)'(DEPTH);
    assign do_rd     = rd_en_i & valid_o;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign do_wr     = wr_en_i & (~full_o | do_rd);
    assign rd_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-8 data bits, optional parity, 1/2 stop bits)
// with break detection feeding a receive FIFO of {ferr, perr, data} words.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV_W = UART_BAUD_DIV_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [BAUD_DIV_W-1:0]         baud_div,
    input  logic [1:0]                    data_bits,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [7:0]                    rd_data,
    output logic                          rd_perr,
    output logic                          rd_ferr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          break_det
);
    logic                  sync1_q, sync2_q;
    rx_state_e             state_q, state_d;
    logic [BAUD_DIV_W-1:0] cnt_q, cnt_d;
    logic [7:0]            data_q, data_d;
    logic [2:0]            idx_q, idx_d;
    data_bits_e            bits_q, bits_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  stop2_q, stop2_d;
    logic                  par_bit_q, par_bit_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  stop_n_q, stop_n_d;
    logic                  push_q, push_d;
    logic [9:0]            word_q, word_d;
    logic                  brk_q, brk_d;
    logic                  overrun_q, overrun_d;
    logic                  tick;
    logic                  fe;
    logic                  brk;
    logic                  full;
    logic [9:0]            head;

    assign tick = cnt_q == '0;
    assign fe   = ferr_q | ~sync2_q;
    assign brk  = (data_q == 8'h00) & ~(par_en_q & par_bit_q) & fe;

    always_comb begin
        state_d   = state_q;
        cnt_d     = tick ? baud_div : cnt_q - 1'b1;
        data_d    = data_q;
        idx_d     = idx_q;
        bits_d    = bits_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        stop_n_d  = stop_n_q;
        push_d    = 1'b0;
        word_d    = word_q;
        brk_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (!sync2_q) begin
                    state_d   = START;
                    cnt_d     = baud_div >> 1;
                    bits_d    = data_bits_e'(data_bits);
                    par_en_d  = parity_en;
                    par_odd_d = parity_odd;
                    stop2_d   = stop2;
                    data_d    = 8'h00;
                    idx_d     = 3'd0;
                    par_bit_d = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    stop_n_d  = 1'b0;
                end
            end
            START: begin
                if (tick) state_d = sync2_q ? IDLE : DATA;
            end
            DATA: begin
                if (tick) begin
                    data_d[idx_q] = sync2_q;
                    idx_d         = idx_q + 3'd1;
                    if (idx_q == last_bit_idx(bits_q)) state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    par_bit_d = sync2_q;
                    perr_d    = (^data_q ^ sync2_q) != par_odd_q;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    ferr_d = fe;
                    if (stop2_q && !stop_n_q) begin
                        stop_n_d = 1'b1;
                    end else begin
                        // Break frames already carry all-zero data, so the word needs no special casing.
                        push_d  = 1'b1;
                        word_d  = {fe, perr_q, data_q};
                        brk_d   = brk;
                        state_d = fe ? WAIT_HIGH : IDLE;
                    end
                end
            end
            WAIT_HIGH: begin
                if (sync2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign overrun_d = clr_overrun ? 1'b0 : (overrun_q | (push_q & full & ~rd_en));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= 8'h00;
            idx_q     <= 3'd0;
            bits_q    <= DB8;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            stop_n_q  <= 1'b0;
            push_q    <= 1'b0;
            word_q    <= 10'h000;
            brk_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= rx;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            bits_q    <= bits_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            stop_n_q  <= stop_n_d;
            push_q    <= push_d;
            word_q    <= word_d;
            brk_q     <= brk_d;
            overrun_q <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (push_q),
        .wr_data_i (word_q),
        .rd_en_i   (rd_en),
        .rd_data_o (head),
        .valid_o   (rd_valid),
        .full_o    (full),
        .count_o   (fifo_count)
    );

    assign rd_data   = head[7:0];
    assign rd_perr   = head[8];
    assign rd_ferr   = head[9];
    assign overrun   = overrun_q;
    assign break_det = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: randomized and directed checks of uart_rx_cfg against a frame-level reference model.
module tb_uart_rx_cfg;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [15:0] baud_div;
    logic [1:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        rd_en;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic        clr_overrun;
    logic        break_det;

    int checks = 0;
    int passed = 0;
    int brk_cnt = 0;

    uart_rx_cfg #(.FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .baud_div    (baud_div),
        .data_bits   (data_bits),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .stop2       (stop2),
        .rd_en       (rd_en),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_perr     (rd_perr),
        .rd_ferr     (rd_ferr),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .break_det   (break_det)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (break_det === 1'b1) brk_cnt++;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

    task automatic set_cfg(input int div, input logic [1:0] db, input logic pen, input logic podd, input logic two);
        baud_div   = 16'(div);
        data_bits  = db;
        parity_en  = pen;
        parity_odd = podd;
        stop2      = two;
    endtask

    task automatic bit_out(input logic b);
        rx = b;
        repeat (int'(baud_div) + 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input logic pen, input logic pbit,
                              input logic s1, input logic s2, input logic two);
        bit_out(1'b0);
        for (int i = 0; i < n; i++) bit_out(d[i]);
        if (pen) bit_out(pbit);
        bit_out(s1);
        if (two) bit_out(s2);
        bit_out(1'b1);
        bit_out(1'b1);
    endtask

    task automatic pop(output logic v, output logic [7:0] d, output logic pe, output logic fe);
        v  = rd_valid;
        d  = rd_data;
        pe = rd_perr;
        fe = rd_ferr;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        clr_overrun = 1'b0;
        set_cfg(15, 2'b11, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rd_valid); else passed++;
        checks++;
        if (fifo_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passed++;
        checks++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
        checks++;
        if (break_det !== 1'b0) $display("FAIL reset_break: got %b want 0", break_det); else passed++;
        checks++;
        if ({rd_ferr, rd_perr, rd_data} !== 10'h000)
            $display("FAIL reset_head: got %h want 000", {rd_ferr, rd_perr, rd_data});
        else passed++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 4'd0)
            $display("FAIL reset_release: got v=%b cnt=%0d want v=0 cnt=0", rd_valid, fifo_count);
        else passed++;
    endtask

    task automatic test_basic;
        logic v, pe, fe;
        logic [7:0] d;
        set_cfg(15, 2'b11, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fifo_count !== 4'd1) $display("FAIL basic_count: got %0d want 1", fifo_count); else passed++;
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b1 || d !== 8'hA5 || pe !== 1'b0 || fe !== 1'b0)
            $display("FAIL basic_word: got v=%b d=%h pe=%b fe=%b want v=1 d=a5 pe=0 fe=0", v, d, pe, fe);
        else passed++;
    endtask

    task automatic test_parity;
        logic v, pe, fe;
        logic [7:0] d;
        set_cfg(15, 2'b10, 1'b1, 1'b0, 1'b0);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b1 || d !== 8'h35 || pe !== 1'b1 || fe !== 1'b0)
            $display("FAIL parity_bad: got v=%b d=%h pe=%b fe=%b want v=1 d=35 pe=1 fe=0", v, d, pe, fe);
        else passed++;
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b1 || d !== 8'h35 || pe !== 1'b0 || fe !== 1'b0)
            $display("FAIL parity_good: got v=%b d=%h pe=%b fe=%b want v=1 d=35 pe=0 fe=0", v, d, pe, fe);
        else passed++;
    endtask

    task automatic test_false_start;
        logic v, pe, fe;
        logic [7:0] d;
        set_cfg(15, 2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (fifo_count !== 4'd0 || rd_valid !== 1'b0)
            $display("FAIL false_start: got cnt=%0d v=%b want cnt=0 v=0", fifo_count, rd_valid);
        else passed++;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b1 || d !== 8'h5A || fe !== 1'b0)
            $display("FAIL after_false_start: got v=%b d=%h fe=%b want v=1 d=5a fe=0", v, d, fe);
        else passed++;
    endtask

    task automatic test_overrun;
        logic v, pe, fe;
        logic [7:0] d;
        set_cfg(15, 2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fifo_count !== 4'd8) $display("FAIL full_count: got %0d want 8", fifo_count); else passed++;
        checks++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else passed++;
        for (int i = 1; i <= 8; i++) begin
            pop(v, d, pe, fe);
            checks++;
            if (v !== 1'b1 || d !== 8'(i))
                $display("FAIL overrun_pop%0d: got v=%b d=%h want v=1 d=%h", i, v, d, 8'(i));
            else passed++;
        end
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b0 || fifo_count !== 4'd0)
            $display("FAIL empty_pop: got v=%b cnt=%0d want v=0 cnt=0", v, fifo_count);
        else passed++;
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) $display("FAIL overrun_clr: got %b want 0", overrun); else passed++;
    endtask

    task automatic test_break;
        logic v, pe, fe;
        logic [7:0] d;
        int b0;
        set_cfg(15, 2'b11, 1'b0, 1'b0, 1'b0);
        b0 = brk_cnt;
        rx = 1'b0;
        repeat (20 * 16) @(negedge clk);
        rx = 1'b1;
        repeat (3 * 16) @(negedge clk);
        checks++;
        if (brk_cnt - b0 !== 1) $display("FAIL break_pulses: got %0d want 1", brk_cnt - b0); else passed++;
        checks++;
        if (fifo_count !== 4'd1) $display("FAIL break_count: got %0d want 1", fifo_count); else passed++;
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b1 || d !== 8'h00 || fe !== 1'b1)
            $display("FAIL break_word: got v=%b d=%h fe=%b want v=1 d=00 fe=1", v, d, fe);
        else passed++;
    endtask

    task automatic test_reset_mid;
        logic v, pe, fe;
        logic [7:0] d;
        set_cfg(15, 2'b11, 1'b0, 1'b0, 1'b0);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (fifo_count !== 4'd1) $display("FAIL reset_mid_count: got %0d want 1", fifo_count); else passed++;
        pop(v, d, pe, fe);
        checks++;
        if (v !== 1'b1 || d !== 8'h3C || fe !== 1'b0)
            $display("FAIL reset_mid_word: got v=%b d=%h fe=%b want v=1 d=3c fe=0", v, d, fe);
        else passed++;
    endtask

    task automatic test_random;
        logic v, pe, fe;
        logic [7:0] d;
        for (int k = 0; k < 25; k++) begin
            int div, n, b0, ones;
            logic [1:0] db;
            logic pen, podd, two, pbit, s1, s2;
            logic [7:0] dat;
            logic exp_pe, exp_fe, exp_brk;
            div  = $urandom_range(3, 15);
            db   = 2'($urandom_range(0, 3));
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            two  = 1'($urandom_range(0, 1));
            n    = 5 + int'(db);
            dat  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom & ((1 << n) - 1));
            pbit = 1'($urandom_range(0, 1));
            s1   = $urandom_range(0, 3) != 0;
            s2   = $urandom_range(0, 3) != 0;
            ones    = $countones(dat) + int'(pbit);
            exp_fe  = !s1 || (two && !s2);
            exp_pe  = pen && ((ones % 2) != int'(podd));
            exp_brk = (dat == 8'h00) && (!pen || !pbit) && exp_fe;
            set_cfg(div, db, pen, podd, two);
            b0 = brk_cnt;
            send_frame(dat, n, pen, pbit, s1, s2, two);
            checks++;
            if (fifo_count !== 4'd1) $display("FAIL rand%0d_count: got %0d want 1", k, fifo_count); else passed++;
            checks++;
            if (brk_cnt - b0 !== int'(exp_brk))
                $display("FAIL rand%0d_break: got %0d want %0d", k, brk_cnt - b0, exp_brk);
            else passed++;
            pop(v, d, pe, fe);
            checks++;
            if (v !== 1'b1 || d !== dat || pe !== exp_pe || fe !== exp_fe)
                $display("FAIL rand%0d_word: got v=%b d=%h pe=%b fe=%b want v=1 d=%h pe=%b fe=%b",
                         k, v, d, pe, fe, dat, exp_pe, exp_fe);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_false_start();
        test_overrun();
        test_break();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
